// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS32_PPL constants, ALU operation encodings and the ID/EX control bundle.
package mips32_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALUOP_W    = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOR  = 4'h5,
    ALU_SLT  = 4'h6,
    ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA,
    ALU_LUI  = 4'hB
  } alu_op_e;

  typedef struct packed {
    logic reg_wr_en;
    logic mem_rd_en;
    logic mem_wr_en;
    logic mem_to_reg;
    logic alu_src;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare: a valid load in EX whose destination feeds the ID instruction.
module hazard_detect
  import mips32_pkg::*;
#(
  parameter int unsigned ADDR_W = mips32_pkg::REG_ADDR_W
) (
  input  logic              valid_id,
  input  logic              valid_ex,
  input  logic              mem_rd_en_ex,
  input  logic [ADDR_W-1:0] wr_addr_ex,
  input  logic [ADDR_W-1:0] rs_id,
  input  logic [ADDR_W-1:0] rt_id,
  input  logic              uses_rt_id,
  output logic              hazard
);

  logic rs_match;
  logic rt_match;
  logic load_in_ex;

  always_comb begin
    load_in_ex = valid_ex & mem_rd_en_ex & (wr_addr_ex != '0);
    rs_match   = (wr_addr_ex == rs_id);
    rt_match   = uses_rt_id & (wr_addr_ex == rt_id);
    hazard     = valid_id & load_in_ex & (rs_match | rt_match);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and IF/ID stall generation.
module id_ex_stage
  import mips32_pkg::*;
#(
  parameter int unsigned DATA_W     = mips32_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = mips32_pkg::REG_ADDR_W,
  parameter int unsigned ALUOP_W    = mips32_pkg::ALUOP_W
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [REG_ADDR_W-1:0] Rs_ID,
  input  logic [REG_ADDR_W-1:0] Rt_ID,
  input  logic [REG_ADDR_W-1:0] Rd_ID,
  input  logic                  UsesRt_ID,
  input  logic                  RegDst_ID,
  input  logic                  RegWrEn_ID,
  input  logic                  MemRdEn_ID,
  input  logic                  MemWrEn_ID,
  input  logic                  MemToReg_ID,
  input  logic                  ALUSrc_ID,
  input  logic [ALUOP_W-1:0]    ALUOp_ID,
  input  logic [DATA_W-1:0]     OperA_ID,
  input  logic [DATA_W-1:0]     OperB_ID,
  input  logic [DATA_W-1:0]     Imm_ID,
  input  logic [DATA_W-1:0]     PC4_ID,
  input  logic                  Valid_ID,
  input  logic                  Flush,
  output logic [REG_ADDR_W-1:0] RegRs_EX,
  output logic [REG_ADDR_W-1:0] RegRt_EX,
  output logic [REG_ADDR_W-1:0] RegWrAddr_EX,
  output logic                  RegWrEn_EX,
  output logic                  MemRdEn_EX,
  output logic                  MemWrEn_EX,
  output logic                  MemToReg_EX,
  output logic                  ALUSrc_EX,
  output logic [ALUOP_W-1:0]    ALUOp_EX,
  output logic [DATA_W-1:0]     OperA_EX,
  output logic [DATA_W-1:0]     OperB_EX,
  output logic [DATA_W-1:0]     Imm_EX,
  output logic [DATA_W-1:0]     PC4_EX,
  output logic                  Valid_EX,
  output logic                  Stall_IF_ID
);

  ctrl_t                 ctrl_id;
  ctrl_t                 ctrl_q;
  logic [REG_ADDR_W-1:0] wr_addr_id;
  logic                  hazard;
  logic                  load_bubble;

  always_comb begin
    ctrl_id.reg_wr_en  = RegWrEn_ID;
    ctrl_id.mem_rd_en  = MemRdEn_ID;
    ctrl_id.mem_wr_en  = MemWrEn_ID;
    ctrl_id.mem_to_reg = MemToReg_ID;
    ctrl_id.alu_src    = ALUSrc_ID;
    wr_addr_id         = RegDst_ID ? Rd_ID : Rt_ID;
  end

  hazard_detect #(
    .ADDR_W(REG_ADDR_W)
  ) u_hazard_detect (
    .valid_id    (Valid_ID),
    .valid_ex    (Valid_EX),
    .mem_rd_en_ex(ctrl_q.mem_rd_en),
    .wr_addr_ex  (RegWrAddr_EX),
    .rs_id       (Rs_ID),
    .rt_id       (Rt_ID),
    .uses_rt_id  (UsesRt_ID),
    .hazard      (hazard)
  );

  // A redirect discards the ID instruction, so holding IF/ID would be pointless.
  assign load_bubble = Flush | hazard;
  assign Stall_IF_ID = rstb & hazard & ~Flush;

  // Reset, flush and load-use bubble all load the same all-zero NOP state.
  always_ff @(posedge clk) begin
    if (!rstb || load_bubble) begin
      ctrl_q       <= NOP_CTRL;
      ALUOp_EX     <= '0;
      RegRs_EX     <= '0;
      RegRt_EX     <= '0;
      RegWrAddr_EX <= '0;
      OperA_EX     <= '0;
      OperB_EX     <= '0;
      Imm_EX       <= '0;
      PC4_EX       <= '0;
      Valid_EX     <= 1'b0;
    end else begin
      ctrl_q       <= Valid_ID ? ctrl_id : NOP_CTRL;
      ALUOp_EX     <= Valid_ID ? ALUOp_ID : '0;
      RegRs_EX     <= Rs_ID;
      RegRt_EX     <= Rt_ID;
      RegWrAddr_EX <= wr_addr_id;
      OperA_EX     <= OperA_ID;
      OperB_EX     <= OperB_ID;
      Imm_EX       <= Imm_ID;
      PC4_EX       <= PC4_ID;
      Valid_EX     <= Valid_ID;
    end
  end

  assign RegWrEn_EX  = ctrl_q.reg_wr_en;
  assign MemRdEn_EX  = ctrl_q.mem_rd_en;
  assign MemWrEn_EX  = ctrl_q.mem_wr_en;
  assign MemToReg_EX = ctrl_q.mem_to_reg;
  assign ALUSrc_EX   = ctrl_q.alu_src;

endmodule
